// File: rtl/systolic_seq_ctrl.sv
// Control sequencer for one ARRAY_DIM x ARRAY_DIM systolic tile: clear, skewed feed, flush, drain, done.
// Produces only enables, indices and strobes; no datapath passes through this block.
module systolic_seq_ctrl #(
   parameter int ARRAY_DIM = 4,
   parameter int K_WIDTH   = 8
) (
   input  logic                           clk_i,
   input  logic                           reset_n,
   input  logic                           start_i,
   input  logic [K_WIDTH-1:0]             k_len_i,
   input  logic                           stall_i,
   output logic                           ready_o,
   output logic                           pe_clear_o,
   output logic                           array_en_o,
   output logic [ARRAY_DIM-1:0]           lane_en_o,
   output logic [ARRAY_DIM*K_WIDTH-1:0]   lane_k_o,
   output logic                           drain_valid_o,
   output logic [$clog2(ARRAY_DIM)-1:0]   drain_row_o,
   output logic                           done_o
);

   localparam int CW = ((K_WIDTH + 1) > $clog2(2 * ARRAY_DIM)) ? (K_WIDTH + 1) : $clog2(2 * ARRAY_DIM);
   localparam int RW = $clog2(ARRAY_DIM);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [K_WIDTH-1:0]   r_k;
   logic [K_WIDTH-1:0]   w_k_nxt;
   logic [CW-1:0]        w_feed_last;
   logic [CW-1:0]        w_phase_last;

   // Feed runs c = 0 .. K+ARRAY_DIM-2 so the last lane sees all K operands.
   assign w_feed_last  = CW'(r_k) + CW'(ARRAY_DIM - 2);
   assign w_phase_last = CW'(ARRAY_DIM - 1);

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_k     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_k     <= w_k_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_k_nxt       = r_k;
      ready_o       = 1'b0;
      pe_clear_o    = 1'b0;
      array_en_o    = 1'b0;
      lane_en_o     = '0;
      lane_k_o      = '0;
      drain_valid_o = 1'b0;
      drain_row_o   = '0;
      done_o        = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
            if (start_i) begin
               w_k_nxt     = k_len_i;
               w_cnt_nxt   = '0;
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            pe_clear_o  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = (r_k == '0) ? S_DONE : S_FEED;
         end
         S_FEED: begin
            if (!stall_i) begin
               array_en_o = 1'b1;
               for (int unsigned i = 0; i < ARRAY_DIM; i++) begin
                  if ((r_cnt >= CW'(i)) && (r_cnt < (CW'(i) + CW'(r_k)))) begin
                     lane_en_o[i]                     = 1'b1;
                     lane_k_o[i*K_WIDTH +: K_WIDTH]   = K_WIDTH'(r_cnt - CW'(i));
                  end
               end
               if (r_cnt == w_feed_last) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_FLUSH;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         S_FLUSH: begin
            if (!stall_i) begin
               array_en_o = 1'b1;
               if (r_cnt == w_phase_last) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_DRAIN;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (!stall_i) begin
               drain_valid_o = 1'b1;
               drain_row_o   = r_cnt[RW-1:0];
               if (r_cnt == w_phase_last) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_DONE;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         S_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: fixed vector table for the stalled K=4 run, hand sequences for reset
// and K=0, and randomized traffic checked against a schedule-position model of the tile.
module tb_systolic_seq_ctrl;

   localparam int D  = 4;
   localparam int KW = 8;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            start_i;
   logic [KW-1:0]   k_len_i;
   logic            stall_i;
   logic            ready_o;
   logic            pe_clear_o;
   logic            array_en_o;
   logic [D-1:0]    lane_en_o;
   logic [D*KW-1:0] lane_k_o;
   logic            drain_valid_o;
   logic [1:0]      drain_row_o;
   logic            done_o;

   systolic_seq_ctrl #(.ARRAY_DIM(D), .K_WIDTH(KW)) dut (
      .clk_i         (clk),
      .reset_n       (reset_n),
      .start_i       (start_i),
      .k_len_i       (k_len_i),
      .stall_i       (stall_i),
      .ready_o       (ready_o),
      .pe_clear_o    (pe_clear_o),
      .array_en_o    (array_en_o),
      .lane_en_o     (lane_en_o),
      .lane_k_o      (lane_k_o),
      .drain_valid_o (drain_valid_o),
      .drain_row_o   (drain_row_o),
      .done_o        (done_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            ready;
      logic            clr;
      logic            aen;
      logic [D-1:0]    len;
      logic [D*KW-1:0] lk;
      logic            dv;
      logic [1:0]      row;
      logic            done;
   } outs_t;

   typedef struct {
      int          cyc;
      bit          st;
      int          k;
      bit          sl;
      logic [18:0] exp;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bit m_busy = 1'b0;
   int m_k    = 0;
   int m_p    = 0;

   vec_t tab[25];

   function automatic outs_t dut_outs();
      outs_t o;
      o = '{ready_o, pe_clear_o, array_en_o, lane_en_o, lane_k_o, drain_valid_o, drain_row_o, done_o};
      return o;
   endfunction

   // Model tracks p = position in the unstalled schedule (1 = clear cycle).
   function automatic outs_t model_out(input bit sl);
      outs_t o;
      int c;
      o = '0;
      if (!m_busy) o.ready = 1'b1;
      else if (m_p == 1) o.clr = 1'b1;
      else if (m_k == 0) o.done = 1'b1;
      else if (m_p <= m_k + D) begin
         if (!sl) begin
            o.aen = 1'b1;
            c = m_p - 2;
            for (int i = 0; i < D; i++) begin
               if (c >= i && c < i + m_k) begin
                  o.len[i] = 1'b1;
                  o.lk[i*KW +: KW] = KW'(c - i);
               end
            end
         end
      end else if (m_p <= m_k + 2*D) begin
         if (!sl) o.aen = 1'b1;
      end else if (m_p <= m_k + 3*D) begin
         if (!sl) begin
            o.dv  = 1'b1;
            o.row = 2'(m_p - (m_k + 2*D + 1));
         end
      end else o.done = 1'b1;
      return o;
   endfunction

   function automatic void model_step(input bit st, input int k, input bit sl);
      int done_p;
      if (!m_busy) begin
         if (st) begin
            m_busy = 1'b1;
            m_k    = k;
            m_p    = 1;
         end
      end else begin
         done_p = (m_k == 0) ? 2 : m_k + 3*D + 1;
         if (m_p == done_p) m_busy = 1'b0;
         else if (!(sl && m_p >= 2)) m_p++;
      end
   endfunction

   function automatic void check_outs(input string name, input outs_t got, input outs_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   function automatic vec_t vrow(input int c, input bit st, input int k, input bit sl,
                                 input bit rdy, input bit clr, input bit aen, input logic [3:0] len,
                                 input logic [7:0] k3, input bit dv, input logic [1:0] row, input bit dn);
      vec_t v;
      v.cyc = c;
      v.st  = st;
      v.k   = k;
      v.sl  = sl;
      v.exp = {rdy, clr, aen, len, k3, dv, row, dn};
      return v;
   endfunction

   task automatic tick(input bit st, input int k, input bit sl);
      outs_t e;
      start_i = st;
      k_len_i = KW'(k);
      stall_i = sl;
      #4;
      e = model_out(sl);
      check_outs($sformatf("model_cyc%0d", cyc), dut_outs(), e);
      @(posedge clk);
      #1;
      model_step(st, k, sl);
      cyc++;
   endtask

   initial begin
      outs_t       rst_exp;
      logic [18:0] got;
      rst_exp       = '0;
      rst_exp.ready = 1'b1;

      // Reset held with start asserted: nothing may be accepted.
      reset_n = 1'b0;
      start_i = 1'b1;
      k_len_i = 8'd4;
      stall_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset_hold", dut_outs(), rst_exp);
      reset_n = 1'b1;
      m_busy  = 1'b0;
      tick(1'b1, 5, 1'b0);
      for (int n = 0; n < 60 && m_busy; n++) tick(1'b0, 0, 1'b0);

      // Stalled K=4 run, ignored starts, then a held start accepted in the first idle cycle.
      tab[0]  = vrow(0,  1, 4, 0,  1, 0, 0, 4'h0, 8'd0, 0, 2'd0, 0);
      tab[1]  = vrow(1,  0, 0, 1,  0, 1, 0, 4'h0, 8'd0, 0, 2'd0, 0);
      tab[2]  = vrow(2,  0, 0, 0,  0, 0, 1, 4'h1, 8'd0, 0, 2'd0, 0);
      tab[3]  = vrow(3,  1, 7, 0,  0, 0, 1, 4'h3, 8'd0, 0, 2'd0, 0);
      tab[4]  = vrow(4,  0, 0, 1,  0, 0, 0, 4'h0, 8'd0, 0, 2'd0, 0);
      tab[5]  = vrow(5,  0, 0, 1,  0, 0, 0, 4'h0, 8'd0, 0, 2'd0, 0);
      tab[6]  = vrow(6,  0, 0, 0,  0, 0, 1, 4'h7, 8'd0, 0, 2'd0, 0);
      tab[7]  = vrow(7,  0, 0, 0,  0, 0, 1, 4'hF, 8'd0, 0, 2'd0, 0);
      tab[8]  = vrow(8,  0, 0, 0,  0, 0, 1, 4'hE, 8'd1, 0, 2'd0, 0);
      tab[9]  = vrow(9,  0, 0, 0,  0, 0, 1, 4'hC, 8'd2, 0, 2'd0, 0);
      tab[10] = vrow(10, 0, 0, 0,  0, 0, 1, 4'h8, 8'd3, 0, 2'd0, 0);
      for (int i = 0; i < 4; i++) begin
         tab[11+i] = vrow(11+i, 0, 0, 0,  0, 0, 1, 4'h0, 8'd0, 0, 2'd0, 0);
         tab[15+i] = vrow(15+i, 0, 0, 0,  0, 0, 0, 4'h0, 8'd0, 1, 2'(i), 0);
      end
      tab[19] = vrow(19, 1, 9, 0,  0, 0, 0, 4'h0, 8'd0, 0, 2'd0, 1);
      tab[20] = vrow(20, 1, 2, 0,  1, 0, 0, 4'h0, 8'd0, 0, 2'd0, 0);
      tab[21] = vrow(21, 0, 9, 0,  0, 1, 0, 4'h0, 8'd0, 0, 2'd0, 0);
      tab[22] = vrow(22, 0, 0, 0,  0, 0, 1, 4'h1, 8'd0, 0, 2'd0, 0);
      tab[23] = vrow(23, 0, 0, 0,  0, 0, 1, 4'h3, 8'd0, 0, 2'd0, 0);
      tab[24] = vrow(24, 0, 0, 0,  0, 0, 1, 4'h6, 8'd0, 0, 2'd0, 0);

      for (int i = 0; i < 25; i++) begin
         start_i = tab[i].st;
         k_len_i = KW'(tab[i].k);
         stall_i = tab[i].sl;
         #4;
         got = {ready_o, pe_clear_o, array_en_o, lane_en_o, lane_k_o[3*KW +: KW],
                drain_valid_o, drain_row_o, done_o};
         n_checks++;
         if (got !== tab[i].exp) begin
            n_fail++;
            $display("FAIL table_cyc%0d: got %h expected %h", tab[i].cyc, got, tab[i].exp);
         end
         @(posedge clk);
         #1;
      end

      // Asynchronous reset mid-feed: outputs must drop before the next edge.
      start_i = 1'b1;
      stall_i = 1'b0;
      #1 reset_n = 1'b0;
      #1 check_outs("reset_midrun_async", dut_outs(), rst_exp);
      @(posedge clk);
      #1;
      check_outs("reset_midrun_hold", dut_outs(), rst_exp);
      reset_n = 1'b1;
      m_busy  = 1'b0;
      for (int n = 0; n < 6; n++) tick(1'b0, 0, 1'b0);

      // K=0 boundary, stall during clear has no effect.
      tick(1'b1, 0, 1'b1);
      tick(1'b0, 0, 1'b1);
      tick(1'b0, 0, 1'b0);
      tick(1'b0, 0, 1'b0);

      // Randomized traffic: starts while busy, varying K, random backpressure.
      for (int n = 0; n < 3000; n++) begin
         int k;
         k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
         tick($urandom_range(0, 3) == 0, k, $urandom_range(0, 3) == 0);
      end
      for (int n = 0; n < 400 && m_busy; n++) tick(1'b0, 0, 1'b0);

      // Maximum K with random stalls.
      tick(1'b1, 255, 1'b0);
      for (int n = 0; n < 600 && m_busy; n++) tick(1'b0, 0, $urandom_range(0, 1) == 1);
      tick(1'b0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

- Sequencer for one ARRAY_DIM×ARRAY_DIM tile of the torus systolic array of int8×int8→int16 PEs.
- Runs one tile computation per start handshake: clear the PE accumulators, feed skewed operands, flush the pipeline, drain results one row per cycle, then report done.
- Sits between the operand/result buffers and the PE array.
- Generates only enables, indices and strobes; it carries no datapath.

## Interface
- ARRAY_DIM, 4: PEs per row/column; number of feed lanes and drain rows.
- K_WIDTH, 8: width of inner-dimension length; K ranges 0..2^K_WIDTH-1.
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  start request; accepted only when ready_o=1.
- k_len_i  in  K_WIDTH  inner dimension K; sampled on acceptance.
- stall_i  in  1  backpressure from the operand feeder or result sink.
- ready_o  out  1  high in IDLE only.
- pe_clear_o  out  1  synchronous clear to the PE array.
- array_en_o  out  1  PE advance enable.
- lane_en_o  out  ARRAY_DIM  per-lane operand valid; the feeder drives zero on a disabled lane.
- lane_k_o  out  ARRAY_DIM*K_WIDTH  per-lane k index; lane i occupies bits [i*K_WIDTH +: K_WIDTH]; zero when its lane_en_o bit is 0.
- drain_valid_o  out  1  result-row capture strobe.
- drain_row_o  out  $clog2(ARRAY_DIM)  row being drained; zero when drain_valid_o=0.
- done_o  out  1  one-cycle completion pulse.

## Operation
- Moore FSM with states IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE. One phase counter, plus the latched value K.
- Every output is a decode of the registered state and counter. No input feeds an output combinationally, except that stall_i masks outputs as described below.
- **IDLE**
  - ready_o=1.
  - start_i=1 latches K=k_len_i and moves to CLEAR.
- **CLEAR** (1 cycle)
  - pe_clear_o=1.
  - If K=0, go to DONE; otherwise go to FEED with counter c=0.
- **FEED** (K+ARRAY_DIM-1 active cycles)
  - array_en_o=1.
  - lane_en_o[i] = (c ≥ i) && (c < i+K).
  - lane_k_o[i] = c-i when enabled.
  - At c = K+ARRAY_DIM-2, go to FLUSH.
- **FLUSH** (ARRAY_DIM active cycles)
  - array_en_o=1; all lane_en_o bits 0.
  - Then go to DRAIN.
- **DRAIN** (ARRAY_DIM active cycles)
  - drain_valid_o=1.
  - drain_row_o counts 0..ARRAY_DIM-1.
  - array_en_o=0.
  - Then go to DONE.
- **DONE** (1 cycle)
  - done_o=1.
  - Then go to IDLE.
- **Stall**
  - In FEED, FLUSH or DRAIN, stall_i=1 freezes the state and counter.
  - While stalled, array_en_o, lane_en_o, lane_k_o, drain_valid_o and drain_row_o are forced to 0.
  - stall_i is ignored in IDLE, CLEAR and DONE.
- **Ignored inputs**
  - start_i outside IDLE is ignored and not queued; this includes the DONE cycle.
  - k_len_i is ignored except at acceptance.
- **Reset**
  - reset_n low immediately forces IDLE, clears the counter and K, and drives every output to 0 except ready_o=1.
  - This applies mid-operation too; the aborted computation is lost.
- Counter width is max(K_WIDTH+1, $clog2(2·ARRAY_DIM)), so K+ARRAY_DIM-1 never wraps. No arithmetic wraps anywhere.

## Timing
- Handshake on edge 0 (start_i && ready_o sampled); cycle n is the interval after edge n.
- Unstalled schedule:
  - Cycle 1: CLEAR.
  - Cycles 2..K+ARRAY_DIM: FEED.
  - Next ARRAY_DIM cycles: FLUSH.
  - Next ARRAY_DIM cycles: DRAIN.
  - Cycle K+3·ARRAY_DIM+1: DONE.
  - Cycle K+3·ARRAY_DIM+2: ready_o high again.
- K=0: done_o in cycle 2; ready_o in cycle 3.
- Each stalled cycle in FEED, FLUSH or DRAIN delays every later event by exactly one cycle.
- A new start can be accepted in the first IDLE cycle after DONE, so back-to-back throughput is K+3·ARRAY_DIM+2 cycles per tile.

## Test plan
- **Reset.** Hold reset_n=0 with start_i=1 → ready_o=1, all other outputs 0. Release; no start is accepted until the first edge with reset_n=1.
- **Nominal run.** ARRAY_DIM=4, K=4, start at edge 0 →
  - pe_clear_o in cycle 1.
  - lane_en_o=0001 in cycle 2, 1111 in cycle 5, 1000 in cycle 8 with lane_k_o[3]=3.
  - FLUSH in cycles 9–12.
  - drain_row_o 0,1,2,3 in cycles 13–16.
  - done_o in cycle 17; ready_o in cycle 18.
- **Stall.** Same run with stall_i=1 in cycles 4–5 →
  - Enables are 0 in cycles 4–5.
  - lane_en_o=1111 in cycle 7.
  - done_o in cycle 19.
  - stall_i=1 during CLEAR has no effect.
- **K=0 boundary.** Start with k_len_i=0 → pe_clear_o in cycle 1, done_o in cycle 2. No lane_en_o or drain_valid_o ever asserts.
- **Start while busy.** Pulse start_i in cycles 3 and 17 (DONE) with a different k_len_i → both ignored and the schedule is unchanged. A start held high is accepted at the cycle-18 edge.
- **Reset mid-run.** Assert reset_n=0 mid-cycle during FEED (cycle 5) → outputs go to their reset values before the next edge. After release the block sits in IDLE with ready_o=1 and no done_o.
